// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: bus widths,
// op and state encodings, and a sign helper used by the divide fix-up.
package muldiv_ctrl_pkg;

   localparam int DATA_W  = 32;
   localparam int DDATA_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_MUL_WAIT = 2'b01,
      ST_DIV_RUN  = 2'b10,
      ST_DONE     = 2'b11
   } state_e;

   // Two's-complement negate when neg is set; used for magnitudes and fix-up.
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
      return neg ? (~v + DATA_W'(1)) : v;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per
// cycle for 32 cycles after load. ready marks the cycle that computes the
// final bit; quotient/remainder carry that step's result combinationally so
// the controller can register them on the same edge.
module div_iter
   import muldiv_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_dividend,
   input  logic [DATA_W-1:0] i_divisor,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_quotient,
   output logic [DATA_W-1:0] o_remainder
);

   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_div;
   logic [4:0]        r_step;
   logic              r_busy;

   logic [DATA_W:0]   w_shift;
   logic [DATA_W:0]   w_diff;
   logic [DATA_W-1:0] w_rem_nxt;
   logic [DATA_W-1:0] w_quo_nxt;

   // One trial subtraction: shift in the next dividend bit, keep the
   // difference when it does not borrow.
   always_comb begin
      w_shift   = {r_rem, r_quo[DATA_W-1]};
      w_diff    = w_shift - {1'b0, r_div};
      w_rem_nxt = w_shift[DATA_W-1:0];
      w_quo_nxt = {r_quo[DATA_W-2:0], 1'b0};
      if (!w_diff[DATA_W]) begin
         w_rem_nxt = w_diff[DATA_W-1:0];
         w_quo_nxt = {r_quo[DATA_W-2:0], 1'b1};
      end
   end

   assign o_ready     = r_busy && (r_step == 5'd31);
   assign o_quotient  = w_quo_nxt;
   assign o_remainder = w_rem_nxt;

   // Divider state: load restarts, otherwise step while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_div  <= '0;
         r_step <= '0;
         r_busy <= 1'b0;
      end else if (i_load) begin
         r_rem  <= '0;
         r_quo  <= i_dividend;
         r_div  <= i_divisor;
         r_step <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt;
         r_step <= r_step + 5'd1;
         if (r_step == 5'd31) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: issues multiplies to an external pipelined
// multiplier, runs the iterative divider, stalls the pipeline until the
// 64-bit {HI,LO} result is ready and pulses done for one cycle.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 3
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [DATA_W-1:0]  src_a,
   input  logic [DATA_W-1:0]  src_b,
   input  logic               flush,
   output logic               mul_start,
   output logic               mul_signed,
   output logic [DATA_W-1:0]  mul_a,
   output logic [DATA_W-1:0]  mul_b,
   input  logic [DDATA_W-1:0] mult_result,
   output logic               stall_req,
   output logic               done,
   output logic [DDATA_W-1:0] result
);

   localparam int              CNT_W = $clog2(MUL_LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MUL_LATENCY);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_mul_signed;
   logic               r_q_neg;
   logic               r_r_neg;

   logic               w_accept;
   logic               w_op_signed;
   logic               w_div_zero;
   logic               w_div_load;
   logic               w_cap_mul;
   logic               w_cap_div;
   logic               w_div_ready;
   logic [DATA_W-1:0]  w_quo;
   logic [DATA_W-1:0]  w_rem;

   assign w_op_signed = ~op[0];
   assign w_div_zero  = op[1] && (src_b == '0);
   assign w_div_load  = w_accept && op[1] && !w_div_zero;

   div_iter u_div_iter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_div_load),
      .i_dividend  (cond_neg(src_a, w_op_signed & src_a[DATA_W-1])),
      .i_divisor   (cond_neg(src_b, w_op_signed & src_b[DATA_W-1])),
      .o_ready     (w_div_ready),
      .o_quotient  (w_quo),
      .o_remainder (w_rem)
   );

   // Next-state and control outputs; flush always returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_cap_mul   = 1'b0;
      w_cap_div   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !flush) begin
               w_accept = 1'b1;
               if (!op[1])          w_state_nxt = ST_MUL_WAIT;
               else if (w_div_zero) w_state_nxt = ST_DONE;
               else                 w_state_nxt = ST_DIV_RUN;
            end
         end
         ST_MUL_WAIT: begin
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == LAT_C) begin
               w_cap_mul   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DIV_RUN: begin
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else if (w_div_ready) begin
               w_cap_div   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign stall_req  = ((r_state == ST_IDLE) && start && !flush) ||
                       (r_state == ST_MUL_WAIT) || (r_state == ST_DIV_RUN);
   assign done       = (r_state == ST_DONE) && !flush;
   assign mul_start  = (r_state == ST_MUL_WAIT) && (r_cnt == ONE_C);
   assign mul_signed = r_mul_signed;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Operand latch, multiply latency counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_mul_signed <= 1'b0;
         r_q_neg      <= 1'b0;
         r_r_neg      <= 1'b0;
         mul_a        <= '0;
         mul_b        <= '0;
         result       <= '0;
      end else begin
         if (w_accept) begin
            mul_a        <= src_a;
            mul_b        <= src_b;
            r_mul_signed <= (op == OP_MULT);
            r_q_neg      <= w_op_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            r_r_neg      <= w_op_signed & src_a[DATA_W-1];
            r_cnt        <= ONE_C;
            if (w_div_zero) begin
               result <= {src_a, {DATA_W{1'b1}}};
            end
         end else if (r_state == ST_MUL_WAIT) begin
            r_cnt <= r_cnt + ONE_C;
         end else begin
            r_cnt <= '0;
         end
         if (w_cap_mul) begin
            result <= mult_result;
         end
         if (w_cap_div) begin
            result <= {cond_neg(w_rem, r_r_neg), cond_neg(w_quo, r_q_neg)};
         end
      end
   end

endmodule
